// File: rtl/bus_arbiter.sv
// bus_arbiter: N-way round-robin arbiter feeding a single registered output slot.
// A requester's word is captured into the output register when the slot is
// free (IDLE) or being drained this cycle (HOLD with out_ready).
// Optional feature macro: BUS_ARBITER_PRIO0_EN -- requester 0 wins any load
// slot in which it is valid; the rest rotate round-robin.
module bus_arbiter #(
  parameter int N  = 4,
  parameter int DW = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req_valid,
  input  logic [N*DW-1:0]      req_data,
  output logic [N-1:0]         req_ready,
  output logic                 out_valid,
  output logic [DW-1:0]        out_data,
  output logic [$clog2(N)-1:0] out_src,
  input  logic                 out_ready,
  output logic                 busy
);

  localparam int SW = $clog2(N);

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_reg;
  state_t          state_next;
  logic [DW-1:0]   out_data_reg;
  logic [SW-1:0]   out_src_reg;
  logic [SW-1:0]   last_grant_reg;

  logic            load_slot;
  logic            any_valid;
  logic            grant_en;
  logic [SW-1:0]   winner;
  logic            found;
  int              idx;

  // Unflattened view of the request words, one entry per requester.
  logic [DW-1:0]   words [N];

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_req
      assign words[gi]     = req_data[gi*DW +: DW];
      // Ready is one-hot on the winner only in a cycle that actually loads.
      assign req_ready[gi] = grant_en && (winner == SW'(gi));
    end
  endgenerate

  assign any_valid = |req_valid;

  // Winner search: first valid requester starting just after the last grant.
  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(last_grant_reg) + k) % N;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = SW'(idx);
      end
    end
`ifdef BUS_ARBITER_PRIO0_EN
    // Requester 0 overrides the rotation whenever it is offering a word.
    if (req_valid[0]) begin
      winner = '0;
    end
`endif
  end

  // State register for the IDLE/HOLD controller.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and load control: a load slot either refills HOLD or empties to IDLE.
  always_comb begin
    state_next = state_reg;
    load_slot  = 1'b0;
    grant_en   = 1'b0;
    case (state_reg)
      IDLE: load_slot = 1'b1;
      HOLD: load_slot = out_ready;
      default: load_slot = 1'b1;
    endcase
    // rst_n gating keeps req_ready low while reset is held, since the
    // forced IDLE state would otherwise look like a load slot.
    grant_en = rst_n && load_slot && any_valid;
    if (load_slot) begin
      state_next = any_valid ? HOLD : IDLE;
    end
  end

  // Output word, source index and rotation pointer update on each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_reg   <= '0;
      out_src_reg    <= '0;
      last_grant_reg <= SW'(N - 1);
    end else if (grant_en) begin
      out_data_reg   <= words[winner];
      out_src_reg    <= winner;
      last_grant_reg <= winner;
    end
  end

  assign out_valid = (state_reg == HOLD);
  assign busy      = (state_reg == HOLD);
  assign out_data  = out_data_reg;
  assign out_src   = out_src_reg;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter (N=4, DW=16).
module tb_bus_arbiter;

  localparam int N  = 4;
  localparam int DW = 16;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N*DW-1:0]   req_data;
  logic [N-1:0]      req_ready;
  logic              out_valid;
  logic [DW-1:0]     out_data;
  logic [1:0]        out_src;
  logic              out_ready;
  logic              busy;

  int total;
  int bad;

  bus_arbiter #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_src   (out_src),
    .out_ready (out_ready),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Check the whole registered output group in one call.
  task automatic chk_out(input string tag, input logic v, input logic [1:0] s, input logic [15:0] d);
    chk({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    chk({tag, ".busy"},      32'(busy),      32'(v));
    chk({tag, ".out_src"},   32'(out_src),   32'(s));
    chk({tag, ".out_data"},  32'(out_data),  32'(d));
  endtask

  initial begin
    logic [1:0] es;
    total     = 0;
    bad       = 0;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    req_valid = 4'b1111;
    req_data  = {16'h1003, 16'h1002, 16'h1001, 16'h1000};

    // Reset: outputs cleared, no ready even with requests pending.
    repeat (2) @(negedge clk);
    #1;
    chk_out("reset", 1'b0, 2'd0, 16'h0000);
    chk("reset.req_ready", 32'(req_ready), 32'h0);
    $display("txn reset: ready=%b valid=%b", req_ready, out_valid);
    @(negedge clk);
    rst_n = 1'b1;

    // All four requesting with the consumer always ready.
    req_valid = 4'b1111;
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
`ifdef BUS_ARBITER_PRIO0_EN
      es = 2'd0;
`else
      es = 2'(i % 4);
`endif
      chk("rr.req_ready", 32'(req_ready), 32'(4'b0001 << es));
      @(negedge clk);
      chk_out("rr", 1'b1, es, 16'h1000 + 16'(es));
      $display("txn rr %0d: src=%0d data=%h", i, out_src, out_data);
    end

    // Drain: no requests, output empties after acceptance.
    req_valid = 4'b0000;
    #1;
    chk("drain.req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    chk("drain.out_valid", 32'(out_valid), 32'h0);
    chk("drain.busy", 32'(busy), 32'h0);
    $display("txn drain: valid=%b busy=%b", out_valid, busy);

    // Stall on requester 2: word held stable, no ready while stalled.
    req_data  = {16'h3333, 16'hA5A5, 16'h1111, 16'h0000};
    req_valid = 4'b0100;
    out_ready = 1'b0;
    #1;
    chk("stall.grant", 32'(req_ready), 32'h4);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("stall.req_ready", 32'(req_ready), 32'h0);
      chk_out("stall", 1'b1, 2'd2, 16'hA5A5);
      $display("txn stall %0d: src=%0d data=%h ready=%b", i, out_src, out_data, req_ready);
      @(negedge clk);
    end
    req_valid = 4'b0000;
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall.empty", 32'(out_valid), 32'h0);

    // Requester 1 appears and vanishes while requester 3 is stalled.
    req_valid = 4'b1000;
    out_ready = 1'b0;
    #1;
    chk("drop.grant3", 32'(req_ready), 32'h8);
    @(negedge clk);
    req_valid = 4'b1010;
    #1;
    chk("drop.stall1", 32'(req_ready), 32'h0);
    @(negedge clk);
    req_valid = 4'b1000;
    #1;
    chk("drop.stall2", 32'(req_ready), 32'h0);
    chk_out("drop.hold", 1'b1, 2'd3, 16'h3333);
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    chk("drop.next", 32'(req_ready), 32'h8);
    @(negedge clk);
    chk_out("drop.out", 1'b1, 2'd3, 16'h3333);
    $display("txn drop: src=%0d data=%h", out_src, out_data);

    // Reset mid-HOLD: outputs clear at once, pointer returns to N-1.
    out_ready = 1'b0;
    req_valid = 4'b1010;
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("midrst", 1'b0, 2'd0, 16'h0000);
    chk("midrst.req_ready", 32'(req_ready), 32'h0);
    $display("txn midrst: valid=%b src=%0d", out_valid, out_src);
    @(negedge clk);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("postrst.first", 32'(req_ready), 32'h2);
    @(negedge clk);
    chk_out("postrst.out1", 1'b1, 2'd1, 16'h1111);
    #1;
    chk("postrst.second", 32'(req_ready), 32'h8);
    @(negedge clk);
    chk_out("postrst.out3", 1'b1, 2'd3, 16'h3333);
    $display("txn postrst: src=%0d data=%h", out_src, out_data);

`ifdef BUS_ARBITER_PRIO0_EN
    // Requester 0 dominates while valid, then rotation resumes after it.
    req_valid = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("prio.req_ready", 32'(req_ready), 32'h1);
      @(negedge clk);
      chk("prio.out_src", 32'(out_src), 32'h0);
    end
    req_valid = 4'b1110;
    #1;
    chk("prio.resume1", 32'(req_ready), 32'h2);
    @(negedge clk);
    #1;
    chk("prio.resume2", 32'(req_ready), 32'h4);
    @(negedge clk);
    $display("txn prio: src=%0d", out_src);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Guard against a hung run.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

endmodule
